// File: rtl/spmv_pkg.sv
// Shared types for the sparse-matrix datapath blocks.
package spmv_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/onehot_to_bin.sv
// Purpose: binary position of a one-hot vector (all-zero input gives zero).
// Latency: combinational.
// Backpressure: none.
module onehot_to_bin #(
    parameter int WIDTH = 16,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] onehot,
    output logic [IDXW-1:0]  bin
);

    // OR-reduce the positions so a one-hot input needs no priority chain.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                bin = bin | IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/mask_drain.sv
// Purpose: drains a request mask, presenting one set bit per transfer, lowest index first.
// Latency: load accepted at edge N gives out_valid in cycle N+1; done pulses the cycle after the drain empties.
// Backpressure: out_ready low holds the presented index; load_ready is low for the whole drain.
module mask_drain
    import spmv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_mask,
    output logic             load_ready,
    input  logic             set_en,
    input  logic [WIDTH-1:0] set_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic [WIDTH-1:0] out_onehot,
    output logic             out_last,
    output logic             done
);

    drain_state_t     state;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] lowbit;
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] pend_nxt;
    logic             xfer;

    assign out_valid  = (state == DRAIN);
    assign load_ready = (state == IDLE);

    assign lowbit     = pending & ~(pending - WIDTH'(1));
    assign out_onehot = out_valid ? lowbit : '0;
    assign out_last   = out_valid && ((pending & (pending - WIDTH'(1))) == '0);

    assign xfer     = out_valid && out_ready;
    assign set_bits = set_en ? set_mask : '0;
    // Set bits are ORed after the clear so a same-cycle re-request survives the transfer.
    assign pend_nxt = (xfer ? (pending & ~lowbit) : pending) | set_bits;

    onehot_to_bin #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_enc (
        .onehot (out_onehot),
        .bin    (out_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // An empty mask completes immediately without entering DRAIN.
                    done <= load_valid && (load_mask == '0);
                    if (load_valid && (load_mask != '0)) begin
                        pending <= load_mask;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    pending <= pend_nxt;
                    if (pend_nxt == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mask_drain.sv
// Directed bench for mask_drain: stimulus pushes expected indices, a negedge monitor checks presentations.
module tb_mask_drain;

    localparam int WIDTH = 16;
    localparam int IDXW  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic [WIDTH-1:0] load_mask;
    logic             load_ready;
    logic             set_en;
    logic [WIDTH-1:0] set_mask;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_idx;
    logic [WIDTH-1:0] out_onehot;
    logic             out_last;
    logic             done;

    typedef struct {
        int idx;
        int last;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    mask_drain #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_mask  (load_mask),
        .load_ready (load_ready),
        .set_en     (set_en),
        .set_mask   (set_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .out_last   (out_last),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, got, got, want, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input int last);
        exp_t e;
        e.idx  = idx;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Ticks until done is seen, then checks the cycle count and that done lasts one cycle.
    task automatic drain_to_done(input string name, input int want_cycles);
        int n;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (done) break;
        end
        chk({name, "_done_cycles"}, n, want_cycles);
        chk({name, "_done_seen"}, int'(done), 1);
        chk({name, "_idle_at_done"}, int'(load_ready), 1);
        tick();
        chk({name, "_done_single"}, int'(done), 0);
    endtask

    task automatic load(input logic [WIDTH-1:0] m);
        load_valid = 1'b1;
        load_mask  = m;
        tick();
        load_valid = 1'b0;
        load_mask  = '0;
    endtask

    // Monitor: every presented index must match the queue head; it pops on a transfer.
    initial begin
        exp_t       e;
        logic [WIDTH-1:0] one;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out: got idx %0d, expected no presentation at %0t",
                             out_idx, $time);
                end else begin
                    e   = exp_q[0];
                    one = 16'h0001;
                    chk("mon_idx",    int'(out_idx),    e.idx);
                    chk("mon_onehot", int'(out_onehot), int'(one << e.idx));
                    chk("mon_last",   int'(out_last),   e.last);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else if (rst === 1'b0) begin
                chk("mon_idle_idx",    int'(out_idx),    0);
                chk("mon_idle_onehot", int'(out_onehot), 0);
                chk("mon_idle_last",   int'(out_last),   0);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_mask  = '0;
        set_en     = 1'b0;
        set_mask   = '0;
        out_ready  = 1'b0;
        #2;
        chk("rst_load_ready", int'(load_ready), 1);
        chk("rst_out_valid",  int'(out_valid),  0);
        chk("rst_out_idx",    int'(out_idx),    0);
        chk("rst_out_onehot", int'(out_onehot), 0);
        chk("rst_out_last",   int'(out_last),   0);
        chk("rst_done",       int'(done),       0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Empty mask: done next cycle, never leaves IDLE.
        load(16'h0000);
        chk("zero_done",       int'(done),       1);
        chk("zero_load_ready", int'(load_ready), 1);
        chk("zero_out_valid",  int'(out_valid),  0);
        tick();
        chk("zero_done_single", int'(done),      0);
        chk("zero_out_valid2",  int'(out_valid), 0);

        // Four bits back-to-back with the consumer always ready.
        out_ready = 1'b1;
        push(0, 0); push(5, 0); push(10, 0); push(15, 1);
        load(16'h8421);
        chk("m8421_valid", int'(out_valid), 1);
        chk("m8421_idx0",  int'(out_idx),   0);
        drain_to_done("m8421", 4);

        // Stall for three cycles: index must hold.
        out_ready = 1'b0;
        push(1, 0); push(2, 1);
        load(16'h0006);
        repeat (3) tick();
        chk("stall_idx",   int'(out_idx),   1);
        chk("stall_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        drain_to_done("stall", 2);

        // Re-request of the bit being transferred plus a lower bit.
        push(4, 1); push(0, 0); push(4, 1);
        load(16'h0010);
        set_en   = 1'b1;
        set_mask = 16'h0011;
        tick();
        set_en   = 1'b0;
        set_mask = '0;
        chk("reset_bit_idx", int'(out_idx), 0);
        drain_to_done("setmask", 2);

        // Reset in the middle of a full drain.
        for (int i = 0; i < 5; i++) push(i, 0);
        load(16'hFFFF);
        repeat (4) tick();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_load_ready", int'(load_ready), 1);
        chk("midrst_out_valid",  int'(out_valid),  0);
        chk("midrst_out_idx",    int'(out_idx),    0);
        chk("midrst_out_onehot", int'(out_onehot), 0);
        chk("midrst_out_last",   int'(out_last),   0);
        chk("midrst_done",       int'(done),       0);
        chk("midrst_q_empty",    exp_q.size(),     0);
        tick();
        chk("midrst_done_hold", int'(done), 0);
        rst = 1'b0;
        tick();
        chk("postrst_done", int'(done), 0);
        push(0, 1);
        load(16'h0001);
        drain_to_done("postrst", 1);

        // A load offered mid-drain must be ignored.
        out_ready = 1'b0;
        push(1, 0); push(2, 1);
        load(16'h0006);
        load_valid = 1'b1;
        load_mask  = 16'h0003;
        #1;
        chk("busy_load_ready", int'(load_ready), 0);
        tick();
        tick();
        chk("busy_idx",    int'(out_idx),    1);
        chk("busy_onehot", int'(out_onehot), 2);
        load_valid = 1'b0;
        load_mask  = '0;
        out_ready  = 1'b1;
        drain_to_done("busy", 2);
        tick();
        chk("busy_stay_idle", int'(out_valid), 0);

        chk("final_q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mask_drain.md
MASK_DRAIN -- requirements
Module: mask_drain

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16: number of request bits in the mask.
REQ-002 The module SHALL have parameter IDXW, default $clog2(WIDTH): width of the binary index output.
REQ-003 The module SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 The module SHALL have port load_valid, input, 1: a new mask is offered.
REQ-006 The module SHALL have port load_mask, input, WIDTH: the mask to drain.
REQ-007 The module SHALL have port load_ready, output, 1: the module can accept a mask; high exactly in IDLE.
REQ-008 The module SHALL have port set_en, input, 1: OR set_mask into the pending vector; honoured in DRAIN only.
REQ-009 The module SHALL have port set_mask, input, WIDTH: bits to add to the pending vector.
REQ-010 The module SHALL have port out_valid, output, 1: an index is presented.
REQ-011 The module SHALL have port out_ready, input, 1: the consumer accepts the presented index.
REQ-012 The module SHALL have port out_idx, output, IDXW: binary position of the lowest set pending bit.
REQ-013 The module SHALL have port out_onehot, output, WIDTH: one-hot form of out_idx.
REQ-014 The module SHALL have port out_last, output, 1: exactly one bit is pending.
REQ-015 The module SHALL have port done, output, 1: one-cycle pulse when a drain completes.

Function
REQ-016 The state machine SHALL have two states: IDLE and DRAIN.
REQ-017 The module SHALL hold a registered pending vector of WIDTH bits.
REQ-018 In IDLE, when load_valid is high and load_mask is non-zero, the module SHALL, on that edge, set pending = load_mask and move to DRAIN.
REQ-019 In IDLE, when load_valid is high and load_mask is zero, the module SHALL stay in IDLE, leave pending zero, and pulse done on the next cycle.
REQ-020 out_valid SHALL equal (state == DRAIN) and SHALL be derived from registers only; a load accepted at edge N gives out_valid high in cycle N+1.
REQ-021 out_onehot SHALL equal pending & ~(pending - 1), and out_idx SHALL be the binary encoding of out_onehot; both SHALL be zero when out_valid is low.
REQ-022 out_last SHALL be high when out_valid is high and (pending & (pending - 1)) == 0.
REQ-023 A transfer SHALL occur when out_valid and out_ready are both high; on that edge pending <= (pending & ~out_onehot) | (set_en ? set_mask : 0).
REQ-024 With no transfer in DRAIN, pending SHALL become pending | (set_en ? set_mask : 0).
REQ-025 out_idx and out_onehot SHALL stay stable while out_valid is high and out_ready is low, unless set_en adds a lower-numbered bit; in that case the lowest pending bit is presented in the next cycle.
REQ-026 If a transfer and a set_mask bit hit the same position in one cycle, that bit SHALL remain pending and SHALL be presented again.
REQ-027 When the next-state pending value after an edge in DRAIN is zero, the module SHALL move to IDLE and pulse done high for exactly the following cycle.
REQ-028 Bits SHALL be served lowest index first and one per transfer, giving at most one index per cycle; a drain with no set_en takes popcount(load_mask) transfers.
REQ-029 In IDLE, set_en SHALL be ignored; in DRAIN, load_valid SHALL be ignored because load_ready is low.

Reset
REQ-030 While rst is high, the module SHALL set state = IDLE and pending = 0.
REQ-031 While rst is high, outputs SHALL be: load_ready 1, out_valid 0, out_idx 0, out_onehot 0, out_last 0, done 0.
REQ-032 Reset asserted mid-drain SHALL discard all pending bits and SHALL NOT pulse done.

Structure
REQ-033 The state enum {IDLE, DRAIN} SHALL be defined in the shared spmv package.
REQ-034 The state enum in that package SHALL be IDXW-independent.
REQ-035 Lowest-bit isolation SHALL be inline.
REQ-036 The one-hot-to-binary conversion SHALL be a sub-module named onehot_to_bin, parameterised by WIDTH, purely combinational.

Verification
REQ-037 Load 16'h0000 -> done pulses one cycle later, state stays IDLE, out_valid never rises.
REQ-038 Load 16'h8421 with out_ready tied 1 -> out_idx 0, 5, 10, 15 on four consecutive cycles; out_last only with 15; done pulses the cycle after 15.
REQ-039 Load 16'h0006, out_ready held low 3 cycles -> out_idx stays 1 and stable; then out_ready 1 -> 1, 2, done.
REQ-040 Load 16'h0010; during the first presentation assert set_en with set_mask 16'h0011 while out_ready is 1 -> transfers of 4, 0, 4 in that order, then done.
REQ-041 Load 16'hFFFF, assert rst after 5 transfers -> all outputs at reset values immediately, no done pulse; a subsequent load of 16'h0001 drains normally.
REQ-042 Load with load_mask 16'h0003 during DRAIN -> ignored, load_ready is 0, and the current drain is unaffected.
